mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the pipelined processor's fetch port and its data port.
//  - Serialises the requests and handles a variable-latency ready handshake.
//  - Produces a pipeline-wide stall until every request presented this cycle is served.
//  - Sits between processor and memory: pc_fetch/instr_fetch on one side, alu_out/write_data/read_data on the other.
// PARAMETERS
//  ADDR_W   32  address width, byte addressed
//  DATA_W   32  word width; byte lanes = DATA_W/8
//  TIMEOUT  64  max wait cycles for mem_ready before err is raised
// PORTS
//  clk        in   1       clock
//  reset      in   1       synchronous, active-high reset
//  if_req     in   1       fetch request; held high until the processor advances
//  if_addr    in   ADDR_W  fetch address (pc_fetch)
//  if_rdata   out  DATA_W  fetched instruction, registered
//  dm_req     in   1       data access request (load or store)
//  dm_we      in   1       1 = store (mem_write_memory)
//  dm_byte    in   1       1 = byte store (write_or_byte); 0 = word
//  dm_addr    in   ADDR_W  data address (alu_out_memory)
//  dm_wdata   in   DATA_W  store data (write_data_memory)
//  dm_rdata   out  DATA_W  load data, registered
//  stall      out  1       freeze all pipeline registers
//  err        out  1       sticky timeout flag
//  mem_en     out  1       memory request valid
//  mem_we     out  1       memory write
//  mem_be     out  DATA_W/8 byte enables
//  mem_addr   out  ADDR_W  memory address, word aligned (addr[1:0] = 0)
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid with mem_ready
//  mem_ready  in   1       completes the current mem_en transaction
// BEHAVIOUR
//  Reset values:
//  - State IDLE; all outputs 0: mem_en, mem_we, mem_be, mem_addr, mem_wdata, if_rdata, dm_rdata, stall, err.
//  - Served flags if_done and dm_done cleared.
//  FSM states IDLE, DATA, FETCH, ADVANCE. Registered outputs; all transitions on rising clk.
//  - IDLE: pending = req & !done per port.
//    - dm pending -> DATA. Data wins because it belongs to the older instruction.
//    - else if pending -> FETCH.
//    - else if any req -> ADVANCE.
//  - DATA/FETCH: mem_en=1; addr, we, be, wdata held stable until mem_ready.
//    - On mem_ready: capture mem_rdata into dm_rdata (loads only) or if_rdata; set the matching done flag.
//    - Then go to DATA/FETCH if the other port is still pending, else ADVANCE.
//  - ADVANCE: lasts 1 cycle; stall=0, both done flags clear, mem_en=0 -> IDLE.
//  - mem_ready while mem_en=0 is ignored.
//  stall = 1 in every cycle outside ADVANCE where if_req|dm_req is high. stall = 0 when no request is present.
//  Byte store: mem_be = 1 << dm_addr[1:0]; mem_wdata = {4{dm_wdata[7:0]}}.
//  Word store: mem_be = 4'hF; mem_wdata = dm_wdata.
//  Reads: mem_we = 0, mem_be = 4'hF.
//  Wait counter:
//  - Cleared on entry to DATA/FETCH; increments each cycle without mem_ready; saturates.
//  - Reaching TIMEOUT sets err (sticky until reset); the FSM keeps waiting.
//  Best-case latency for a fetch+load cycle: 2 mem transactions + 1 ADVANCE cycle.
//  Reset mid-transaction: mem_en drops the cycle after reset is sampled, with no partial capture.
//  - Memory is required to tolerate an abandoned request.
//  Requests that drop while unserved: done flags still clear only in ADVANCE; a dropped request is simply not issued.
// STRUCTURE
//  Package mips_mem_pkg:
//  - arb_state_t enum {IDLE, DATA, FETCH, ADVANCE}.
//  - BE_WORD constant.
//  - function byte_be(addr[1:0]).
//  Sub-module mem_byte_steer (combinational): takes dm_addr[1:0], dm_byte, dm_we, dm_wdata and produces mem_be and mem_wdata.
//  FSM, wait counter and response registers stay in mem_port_arbiter.
// TESTING
//  - Fetch only: if_req=1, if_addr=0x40, mem_ready after 1 cycle with rdata=0x2008_0005 -> if_rdata=0x2008_0005; stall high for 2 cycles, then low in ADVANCE.
//  - Simultaneous: if_req and dm_req (load 0x100) together -> data transaction issued first (mem_addr=0x100), then fetch; dm_rdata/if_rdata correct; 1 ADVANCE cycle.
//  - Byte store: dm_we=1, dm_byte=1, dm_addr=0x103, wdata=0x1234_56AB -> mem_be=4'b1000, mem_wdata=0xABAB_ABAB, mem_addr=0x100.
//  - Wait states: mem_ready withheld 5 cycles -> mem_addr/mem_wdata stable throughout; stall held; completes correctly.
//  - Timeout: TIMEOUT=8, mem_ready never -> err=1 at the 8th wait cycle and stays set; reset clears it.
//  - Reset mid-DATA: assert reset during wait -> next cycle mem_en=0, stall=0, state IDLE, rdata regs 0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and byte-lane helpers for the fetch/data memory port arbiter.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DATA    = 2'd1,
      FETCH   = 2'd2,
      ADVANCE = 2'd3
   } arb_state_t;

   localparam int unsigned BE_W = 4;
   localparam logic [BE_W-1:0] BE_WORD = 4'hF;

   // One-hot byte enable for the lane selected by the low address bits.
   function automatic logic [BE_W-1:0] byte_be(input logic [1:0] lane);
      byte_be = BE_W'(1) << lane;
   endfunction

endpackage

// File: rtl/mem_byte_steer.sv
// Data-port write steering: byte enables and lane-replicated write data.
module mem_byte_steer
   import mips_mem_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [1:0]          dm_lane,
   input  logic                dm_byte,
   input  logic                dm_we,
   input  logic [DATA_W-1:0]   dm_wdata,
   output logic [DATA_W/8-1:0] be_c,
   output logic [DATA_W-1:0]   wdata_c
);

   localparam int unsigned NB = DATA_W / 8;

   // Byte stores replicate the low byte to every lane; the enable picks the target.
   always_comb begin
      be_c    = NB'(BE_WORD);
      wdata_c = '0;
      if (dm_we) begin
         if (dm_byte) begin
            be_c    = NB'(byte_be(dm_lane));
            wdata_c = {NB{dm_wdata[7:0]}};
         end else begin
            wdata_c = dm_wdata;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data requests onto one single-ported memory and
// stalls the pipeline until every request presented this cycle has been served.
module mem_port_arbiter
   import mips_mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic                dm_byte,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                stall,
   output logic                err,
   output logic                mem_en,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ready
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   arb_state_t state_q, state_d;

   logic              if_done_q, if_done_d;
   logic              dm_done_q, dm_done_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic              err_q, err_d;
   logic              stall_q, stall_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [NB-1:0]     mem_be_q, mem_be_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

   logic              xfer_c;
   logic              if_pend_c;
   logic              dm_pend_c;
   logic              hold_c;
   logic [NB-1:0]     steer_be_c;
   logic [DATA_W-1:0] steer_wdata_c;
   logic              unused_if_lane_c;

   mem_byte_steer #(
      .DATA_W (DATA_W)
   ) u_steer (
      .dm_lane  (dm_addr[1:0]),
      .dm_byte  (dm_byte),
      .dm_we    (dm_we),
      .dm_wdata (dm_wdata),
      .be_c     (steer_be_c),
      .wdata_c  (steer_wdata_c)
   );

   // A ready pulse only counts while a transaction is actually on the bus.
   assign xfer_c           = mem_en_q & mem_ready;
   assign hold_c           = mem_en_q & ~mem_ready;
   assign if_pend_c        = if_req & ~if_done_q;
   assign dm_pend_c        = dm_req & ~dm_done_q;
   assign unused_if_lane_c = ^if_addr[1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Data is served before fetch: it belongs to the older instruction.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (dm_pend_c) begin
               state_d = DATA;
            end else if (if_pend_c) begin
               state_d = FETCH;
            end else if (if_req || dm_req) begin
               state_d = ADVANCE;
            end
         end
         DATA: begin
            if (xfer_c) begin
               state_d = if_pend_c ? FETCH : ADVANCE;
            end
         end
         FETCH: begin
            if (xfer_c) begin
               state_d = dm_pend_c ? DATA : ADVANCE;
            end
         end
         ADVANCE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      if_done_d   = if_done_q;
      dm_done_d   = dm_done_q;
      wait_cnt_d  = '0;
      err_d       = err_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_be_d    = '0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      stall_d     = (state_d != ADVANCE) && (if_req || dm_req);

      if (state_q == ADVANCE) begin
         if_done_d = 1'b0;
         dm_done_d = 1'b0;
      end

      if (xfer_c) begin
         if (state_q == DATA) begin
            dm_done_d = 1'b1;
            if (!mem_we_q) begin
               dm_rdata_d = mem_rdata;
            end
         end else begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
         end
      end

      // Saturating wait count; err is sticky and the FSM keeps waiting.
      if (hold_c) begin
         wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
         if (wait_cnt_d == CNT_MAX) begin
            err_d = 1'b1;
         end
      end

      if (state_d == DATA || state_d == FETCH) begin
         mem_en_d = 1'b1;
         if (hold_c) begin
            mem_we_d    = mem_we_q;
            mem_be_d    = mem_be_q;
            mem_addr_d  = mem_addr_q;
            mem_wdata_d = mem_wdata_q;
         end else if (state_d == DATA) begin
            mem_we_d    = dm_we;
            mem_be_d    = steer_be_c;
            mem_addr_d  = {dm_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = steer_wdata_c;
         end else begin
            mem_be_d    = NB'(BE_WORD);
            mem_addr_d  = {if_addr[ADDR_W-1:2], 2'b00};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         if_done_q   <= 1'b0;
         dm_done_q   <= 1'b0;
         wait_cnt_q  <= '0;
         err_q       <= 1'b0;
         stall_q     <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         if_done_q   <= if_done_d;
         dm_done_q   <= dm_done_d;
         wait_cnt_q  <= wait_cnt_d;
         err_q       <= err_d;
         stall_q     <= stall_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end

   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign stall     = stall_q;
   assign err       = err_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory responder plus a
// transaction-level reference of what each processor cycle should cause.
module tb_mem_port_arbiter;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned TMO = 8;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          we;
      logic [3:0]    be;
      logic [DW-1:0] wdata;
   } txn_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          dm_req;
   logic          dm_we;
   logic          dm_byte;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] dm_rdata;
   logic          stall;
   logic          err;
   logic          mem_en;
   logic          mem_we;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ready = 1'b0;

   int   tests_run    = 0;
   int   tests_failed = 0;
   int   mem_wait     = 0;
   int   wcnt         = 0;
   bit   mem_mute     = 1'b0;
   bit   force_ready  = 1'b0;
   txn_t hold_t;
   txn_t obs_q[$];

   logic [DW-1:0] mem_a [int unsigned];
   logic [DW-1:0] ref_a [int unsigned];
   logic [DW-1:0] exp_if = '0;
   logic [DW-1:0] exp_dm = '0;

   mem_port_arbiter #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TMO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_byte   (dm_byte),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .stall     (stall),
      .err       (err),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_word(input int unsigned k);
      return (k * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [DW-1:0] rd_mem(input int unsigned k);
      return mem_a.exists(k) ? mem_a[k] : init_word(k);
   endfunction

   function automatic logic [DW-1:0] rd_ref(input int unsigned k);
      return ref_a.exists(k) ? ref_a[k] : init_word(k);
   endfunction

   // Memory: answers each request after mem_wait idle cycles, checks the request stays put.
   always @(negedge clk) begin
      logic [DW-1:0] word;
      int unsigned   k;
      txn_t          cur;
      if (mem_ready) begin
         mem_ready = 1'b0;
         wcnt      = 0;
      end
      if (reset) begin
         wcnt = 0;
      end else if (force_ready) begin
         mem_ready = 1'b1;
         mem_rdata = 32'hDEAD_BEEF;
      end else if (mem_en === 1'b1 && !mem_mute) begin
         cur = {mem_addr, mem_we, mem_be, mem_wdata};
         if (wcnt == 0) begin
            hold_t = cur;
         end else begin
            tests_run++;
            if (cur !== hold_t) begin
               tests_failed++;
               $display("FAIL hold_stable: got %h want %h", cur, hold_t);
            end
         end
         if (wcnt >= mem_wait) begin
            k    = mem_addr >> 2;
            word = rd_mem(k);
            obs_q.push_back(cur);
            mem_rdata = word;
            if (mem_we) begin
               for (int b = 0; b < 4; b++) begin
                  if (mem_be[b]) word[8*b +: 8] = mem_wdata[8*b +: 8];
               end
               mem_a[k] = word;
            end
            mem_ready = 1'b1;
         end else begin
            wcnt++;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // One processor cycle: reference computes expected bus traffic, stall length and rdata.
   task automatic do_op(input bit ireq, input logic [AW-1:0] iaddr,
                        input bit dreq, input bit dwe, input bit dbyte,
                        input logic [AW-1:0] daddr, input logic [DW-1:0] dwdata,
                        input int w, input string name);
      txn_t          exp_q[$];
      txn_t          t;
      int unsigned   k;
      int            lane;
      logic [DW-1:0] word;
      int            exp_stall;
      int            nstall;
      bit            seen_adv;

      exp_stall = 0;
      if (dreq) begin
         k       = daddr >> 2;
         lane    = int'(daddr & 32'h3);
         word    = rd_ref(k);
         t.addr  = daddr & ~32'h3;
         t.we    = dwe;
         t.be    = 4'hF;
         t.wdata = '0;
         if (dwe && dbyte) begin
            t.be    = 4'b0001 << lane;
            t.wdata = {4{dwdata[7:0]}};
            word[8*lane +: 8] = dwdata[7:0];
            ref_a[k] = word;
         end else if (dwe) begin
            t.wdata  = dwdata;
            ref_a[k] = dwdata;
         end else begin
            exp_dm = word;
         end
         exp_q.push_back(t);
         exp_stall += w + 1;
      end
      if (ireq) begin
         k       = iaddr >> 2;
         t.addr  = iaddr & ~32'h3;
         t.we    = 1'b0;
         t.be    = 4'hF;
         t.wdata = '0;
         exp_if  = rd_ref(k);
         exp_q.push_back(t);
         exp_stall += w + 1;
      end

      obs_q.delete();
      mem_wait = w;
      if_req   = ireq;
      if_addr  = iaddr;
      dm_req   = dreq;
      dm_we    = dwe;
      dm_byte  = dbyte;
      dm_addr  = daddr;
      dm_wdata = dwdata;

      nstall   = 0;
      seen_adv = 1'b0;
      for (int c = 0; c < 200 && !seen_adv; c++) begin
         @(negedge clk);
         if (stall === 1'b1) nstall++;
         else seen_adv = 1'b1;
      end

      tests_run++;
      if (!seen_adv) begin
         tests_failed++;
         $display("FAIL %s advance_timeout: stall still %b after %0d cycles", name, stall, nstall);
      end
      tests_run++;
      if (nstall !== exp_stall) begin
         tests_failed++;
         $display("FAIL %s stall_cycles: got %0d want %0d", name, nstall, exp_stall);
      end
      tests_run++;
      if (mem_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s advance_mem_en: got %b want 0", name, mem_en);
      end
      tests_run++;
      if (obs_q.size() != exp_q.size()) begin
         tests_failed++;
         $display("FAIL %s txn_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            tests_run++;
            if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].we !== exp_q[i].we ||
                obs_q[i].be !== exp_q[i].be ||
                (exp_q[i].we && obs_q[i].wdata !== exp_q[i].wdata)) begin
               tests_failed++;
               $display("FAIL %s txn%0d: got %h want %h", name, i, obs_q[i], exp_q[i]);
            end
         end
      end
      tests_run++;
      if (if_rdata !== exp_if) begin
         tests_failed++;
         $display("FAIL %s if_rdata: got %h want %h", name, if_rdata, exp_if);
      end
      tests_run++;
      if (dm_rdata !== exp_dm) begin
         tests_failed++;
         $display("FAIL %s dm_rdata: got %h want %h", name, dm_rdata, exp_dm);
      end

      if_req = 1'b0;
      dm_req = 1'b0;
      dm_we  = 1'b0;
      @(negedge clk);
      tests_run++;
      if (stall !== 1'b0 || mem_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s idle_after: stall=%b mem_en=%b want 0 0", name, stall, mem_en);
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      if_req   = 1'b0;
      if_addr  = '0;
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      dm_byte  = 1'b0;
      dm_addr  = '0;
      dm_wdata = '0;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata, if_rdata, dm_rdata, stall, err} !== '0) begin
         tests_failed++;
         $display("FAIL reset_values: en=%b we=%b be=%h addr=%h wd=%h if=%h dm=%h stall=%b err=%b want all 0",
                  mem_en, mem_we, mem_be, mem_addr, mem_wdata, if_rdata, dm_rdata, stall, err);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if (stall !== 1'b0 || mem_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_idle: stall=%b mem_en=%b want 0 0", stall, mem_en);
      end
   endtask

   task automatic test_fetch_only();
      mem_a[32'h40 >> 2] = 32'h2008_0005;
      ref_a[32'h40 >> 2] = 32'h2008_0005;
      do_op(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, '0, '0, 1, "fetch_only");
      tests_run++;
      if (if_rdata !== 32'h2008_0005) begin
         tests_failed++;
         $display("FAIL fetch_only_value: got %h want 20080005", if_rdata);
      end
   endtask

   task automatic test_simultaneous();
      do_op(1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 32'h100, '0, 0, "simultaneous");
   endtask

   task automatic test_byte_store();
      do_op(1'b0, '0, 1'b1, 1'b1, 1'b1, 32'h103, 32'h1234_56AB, 0, "byte_store");
      do_op(1'b0, '0, 1'b1, 1'b0, 1'b0, 32'h100, '0, 0, "byte_store_rb");
   endtask

   task automatic test_wait_states();
      do_op(1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 32'h204, 32'hCAFE_F00D, 5, "wait_store");
      do_op(1'b1, 32'h208, 1'b1, 1'b0, 1'b0, 32'h204, '0, 5, "wait_load");
   endtask

   task automatic test_spurious_ready();
      @(negedge clk);
      #1 force_ready = 1'b1;
      @(negedge clk);
      #1 force_ready = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if (if_rdata !== exp_if || dm_rdata !== exp_dm || mem_en !== 1'b0 || stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL spurious_ready: if=%h dm=%h en=%b stall=%b want if=%h dm=%h en=0 stall=0",
                  if_rdata, dm_rdata, mem_en, stall, exp_if, exp_dm);
      end
      do_op(1'b1, 32'h48, 1'b0, 1'b0, 1'b0, '0, '0, 0, "after_spurious");
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         bit            ir;
         bit            dr;
         bit            we;
         bit            by;
         logic [AW-1:0] ia;
         logic [AW-1:0] da;
         logic [DW-1:0] wd;
         int            w;
         ir = 1'($urandom_range(0, 1));
         dr = 1'($urandom_range(0, 1));
         we = 1'($urandom_range(0, 1));
         by = 1'($urandom_range(0, 1));
         ia = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
         da = 32'h1000 + 32'($urandom_range(0, 63));
         wd = $urandom;
         w  = int'($urandom_range(0, 4));
         do_op(ir, ia, dr, we, by, da, wd, w, "random");
      end
      tests_run++;
      if (err !== 1'b0) begin
         tests_failed++;
         $display("FAIL random_no_err: got %b want 0", err);
      end
   endtask

   task automatic test_timeout();
      mem_mute = 1'b1;
      if_req   = 1'b1;
      if_addr  = 32'h300;
      for (int c = 1; c <= int'(TMO); c++) begin
         @(negedge clk);
         if (c == int'(TMO)) begin
            tests_run++;
            if (err !== 1'b0 || mem_en !== 1'b1) begin
               tests_failed++;
               $display("FAIL timeout_before: err=%b mem_en=%b want 0 1", err, mem_en);
            end
         end
      end
      @(negedge clk);
      tests_run++;
      if (err !== 1'b1) begin
         tests_failed++;
         $display("FAIL timeout_set: err got %b want 1", err);
      end
      repeat (20) @(negedge clk);
      tests_run++;
      if (err !== 1'b1 || stall !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 32'h300) begin
         tests_failed++;
         $display("FAIL timeout_sticky: err=%b stall=%b en=%b addr=%h want 1 1 1 300",
                  err, stall, mem_en, mem_addr);
      end
      reset = 1'b1;
      @(negedge clk);
      reset    = 1'b0;
      if_req   = 1'b0;
      mem_mute = 1'b0;
      exp_if   = '0;
      exp_dm   = '0;
      tests_run++;
      if (err !== 1'b0 || mem_en !== 1'b0 || stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL timeout_reset: err=%b en=%b stall=%b want 0 0 0", err, mem_en, stall);
      end
   endtask

   task automatic test_reset_mid_data();
      do_op(1'b1, 32'h50, 1'b1, 1'b0, 1'b0, 32'h54, '0, 0, "preload");
      mem_mute = 1'b1;
      dm_req   = 1'b1;
      dm_we    = 1'b0;
      dm_addr  = 32'h180;
      if_req   = 1'b1;
      if_addr  = 32'h58;
      repeat (3) @(negedge clk);
      tests_run++;
      if (mem_en !== 1'b1 || mem_addr !== 32'h180) begin
         tests_failed++;
         $display("FAIL midreset_busy: en=%b addr=%h want 1 180", mem_en, mem_addr);
      end
      reset = 1'b1;
      @(negedge clk);
      tests_run++;
      if (mem_en !== 1'b0 || stall !== 1'b0 || if_rdata !== '0 || dm_rdata !== '0) begin
         tests_failed++;
         $display("FAIL midreset_clear: en=%b stall=%b if=%h dm=%h want 0 0 0 0",
                  mem_en, stall, if_rdata, dm_rdata);
      end
      reset    = 1'b0;
      if_req   = 1'b0;
      dm_req   = 1'b0;
      mem_mute = 1'b0;
      exp_if   = '0;
      exp_dm   = '0;
      @(negedge clk);
      do_op(1'b1, 32'h58, 1'b1, 1'b0, 1'b0, 32'h180, '0, 2, "after_midreset");
   endtask

   initial begin
      test_reset();
      test_fetch_only();
      test_simultaneous();
      test_byte_store();
      test_wait_states();
      test_spurious_ready();
      test_random();
      test_timeout();
      test_reset_mid_data();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
